uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame.
REQ-002 Parameter N_SBIT_TICKS, default 16, oversampling ticks per stop bit.
REQ-003 Parameter N_OVERSAMPLE, default 16, oversampling ticks per data bit; fixed at 16 in this revision.
REQ-004 i_clock  input  1  system clock; all logic on rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_tick  input  1  one-clock baud-rate pulse from the baud-rate generator, 16x the bit rate.
REQ-007 i_rx  input  1  serial line, idle high, asynchronous to i_clock.
REQ-008 o_data  output  NB_DATA  last received word, LSB received first.
REQ-009 o_rx_done  output  1  one-clock pulse when a frame completes.
REQ-010 o_frame_err  output  1  one-clock pulse, coincident with o_rx_done, when the stop bit sampled low.
REQ-011 o_parity_err  output  1  one-clock pulse, coincident with o_rx_done, on parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; every sample and edge detection SHALL use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro-only) and STOP.
REQ-014 The tick counter SHALL advance only in cycles with i_tick=1 and SHALL clear on every state change.
REQ-015 IDLE: on rx_s=0 -> START, tick count 0, independent of i_tick.
REQ-016 START: on the i_tick where count==7 (mid start bit), rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: on the i_tick where count==15, right-shift rx_s into the shift register MSB and clear count; after bit NB_DATA-1 -> PARITY if enabled, else STOP.
REQ-018 PARITY: on the i_tick where count==15, sample the parity bit -> STOP.
REQ-019 STOP: on the i_tick where count==N_SBIT_TICKS-1, sample the stop bit and -> IDLE.
REQ-020 In the clock after the stop sample, o_rx_done SHALL be 1 for exactly one cycle, o_data SHALL load the shift register, and o_frame_err SHALL equal ~stop_sample.
REQ-021 A frame with a framing error SHALL still update o_data and pulse o_rx_done.
REQ-022 o_data SHALL hold its value between o_rx_done pulses.
REQ-023 From IDLE after STOP, a low rx_s SHALL start a new frame immediately, so back-to-back frames lose no bits.
REQ-024 In cycles with i_tick=0, state, counters and shift register SHALL hold.

Reset
REQ-025 When i_reset=1 at a clock edge: state=IDLE, counters=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abort the frame with no o_rx_done pulse; reception resumes at the next falling edge after i_reset=0.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state, even-parity check and o_parity_err present; o_parity_err = XOR(data bits, parity bit).
REQ-028 Macro undefined: no PARITY state and no o_parity_err port; frame = start + NB_DATA + stop.

Verification
REQ-029 i_tick every 4 clocks; send 0xA5 with one stop bit -> o_data=0xA5, single o_rx_done pulse, o_frame_err=0.
REQ-030 Drive i_rx low for 4 ticks, then high -> FSM returns to IDLE, no o_rx_done, o_data unchanged.
REQ-031 Send 0x3C with stop bit 0 -> o_data=0x3C, o_rx_done and o_frame_err pulse together.
REQ-032 Assert i_reset during bit 3 of 0xFF, then send 0x12 -> no pulse for the aborted frame; o_data=0x12 after the second frame.
REQ-033 Send 0x01 then 0x80 back-to-back -> two o_rx_done pulses, o_data=0x01 then 0x80.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> o_parity_err=1; with parity bit 1 -> o_parity_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 2-flop input synchronizer,
// mid-bit sampling and registered one-cycle completion pulses.
// Optional even-parity check is enabled by defining UART_RX_PARITY_EN,
// which adds a PARITY state and the o_parity_err output.
module uart_rx #(
    parameter int NB_DATA      = 8,
    parameter int N_SBIT_TICKS = 16,
    parameter int N_OVERSAMPLE = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_err,
`endif
    output logic               o_frame_err
);

    localparam int CNT_MAX = (N_SBIT_TICKS > N_OVERSAMPLE) ? N_SBIT_TICKS : N_OVERSAMPLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(N_OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N_OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(N_SBIT_TICKS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NB_DATA - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic               rx_meta_q, rx_s_q;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_DATA-1:0] data_q;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d;
    logic               perr_q, perr_d;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: frame FSM, tick/bit counters, shift register
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Start detection does not wait for a tick so a frame
                // following a stop bit loses no time.
                if (!rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        // Line back high at mid start bit: treat as a glitch
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[NB_DATA-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        par_d      = rx_s_q;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        ferr_d     = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit must XOR to 0
                        perr_d     = ^{shift_q, par_q};
`endif
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
            end
        endcase
    end

    // State, counter and output registers; outputs load one clock after the stop sample
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            if (done_d) begin
                data_q <= shift_q;
            end
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames against a queue-based frame model,
// with a per-cycle output check and literal expectations after each scenario.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

    logic       clk;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx #(
        .NB_DATA      (8),
        .N_SBIT_TICKS (16),
        .N_OVERSAMPLE (16)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (o_parity_err),
`endif
        .o_frame_err  (o_frame_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_data;
    int         n_assert;
    int         n_fail;
    int         done_cnt;
    logic       last_ferr;
    logic       last_perr;
    bit         checking;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one clock high out of every four
    initial begin
        int ph;
        ph = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            i_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Per-cycle compare against the frame model
    initial begin
        logic rst_e;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_e = i_reset;
            #1;
            if (checking) begin
                if (rst_e) begin
                    exp_data = 8'h00;
                    chk("rst_done", o_rx_done, 0);
                    chk("rst_data", o_data, 0);
                    chk("rst_ferr", o_frame_err, 0);
`ifdef UART_RX_PARITY_EN
                    chk("rst_perr", o_parity_err, 0);
`endif
                end else if (o_rx_done === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("frame_data", o_data, e.data);
                    chk("frame_ferr", o_frame_err, e.ferr);
                    last_ferr = o_frame_err;
`ifdef UART_RX_PARITY_EN
                    chk("frame_perr", o_parity_err, e.perr);
                    last_perr = o_parity_err;
`endif
                    exp_data = e.data;
                    done_cnt++;
                end else begin
                    chk("no_done", o_rx_done, 0);
                    chk("hold_data", o_data, exp_data);
                    chk("idle_ferr", o_frame_err, 0);
`ifdef UART_RX_PARITY_EN
                    chk("idle_perr", o_parity_err, 0);
`endif
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Full frame; stop_len lets a low stop bit end early so its tail
    // is not read back as a new start bit.
    task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input int stop_len);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.perr = (^d) ^ pbit;
        exp_q.push_back(e);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold(pbit, BIT_CLKS);
`endif
        hold(stop, stop_len);
        i_rx = 1'b1;
    endtask

    task automatic check_drained(input string name);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        done_cnt  = 0;
        last_ferr = 1'b0;
        last_perr = 1'b0;
        exp_data  = 8'h00;
        checking  = 0;
        i_rx      = 1'b1;
        i_reset   = 1'b1;
        repeat (3) @(negedge clk);
        checking = 1;
        @(negedge clk);
        i_reset = 1'b0;
        hold(1'b1, 2 * BIT_CLKS);

        // Nominal frame
        send(8'hA5, ^8'hA5, 1'b1, BIT_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        check_drained("a5_drained");
        chk("lit_a5_data", o_data, 8'hA5);
        chk("lit_a5_cnt", done_cnt, 1);
        chk("lit_a5_ferr", last_ferr, 0);

        // Start-bit glitch of 4 ticks
        hold(1'b0, 16);
        hold(1'b1, 3 * BIT_CLKS);
        chk("lit_glitch_data", o_data, 8'hA5);
        chk("lit_glitch_cnt", done_cnt, 1);

        // Framing error
        send(8'h3C, ^8'h3C, 1'b0, 48);
        hold(1'b1, 2 * BIT_CLKS);
        check_drained("3c_drained");
        chk("lit_3c_data", o_data, 8'h3C);
        chk("lit_3c_cnt", done_cnt, 2);
        chk("lit_3c_ferr", last_ferr, 1);

        // Reset in the middle of bit 3 of 0xFF
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold(1'b1, BIT_CLKS);
        hold(1'b1, BIT_CLKS / 2);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        hold(1'b1, 6 * BIT_CLKS);
        chk("lit_abort_data", o_data, 8'h00);
        chk("lit_abort_cnt", done_cnt, 2);
        send(8'h12, ^8'h12, 1'b1, BIT_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        check_drained("12_drained");
        chk("lit_12_data", o_data, 8'h12);
        chk("lit_12_cnt", done_cnt, 3);

        // Back-to-back frames
        send(8'h01, ^8'h01, 1'b1, BIT_CLKS);
        chk("lit_b2b_first", o_data, 8'h01);
        send(8'h80, ^8'h80, 1'b1, BIT_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        check_drained("b2b_drained");
        chk("lit_b2b_data", o_data, 8'h80);
        chk("lit_b2b_cnt", done_cnt, 5);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right
        send(8'h07, 1'b0, 1'b1, BIT_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        chk("lit_par0_perr", last_perr, 1);
        send(8'h07, 1'b1, 1'b1, BIT_CLKS);
        hold(1'b1, 2 * BIT_CLKS);
        chk("lit_par1_perr", last_perr, 0);
        check_drained("par_drained");
        chk("lit_par_data", o_data, 8'h07);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
